// File: rtl/ncu_sii_pkg.sv
// Shared types and constants for the NCU SII ingress path.
package ncu_sii_pkg;

  localparam int NUM_BEATS = 4;
  localparam int BEAT_W    = 32;
  localparam int PKT_W     = 128;
  localparam int HDR_W     = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT  = 2'd1,
    CAP  = 2'd2
  } ncu_state_t;

  // Even parity per half-word: the parity bit must equal the XOR of its 16 data bits.
  function automatic logic beat_perr(input logic [BEAT_W-1:0] data,
                                     input logic [1:0]        dpar);
    return (dpar[1] != ^data[31:16]) || (dpar[0] != ^data[15:0]);
  endfunction

endpackage

// File: rtl/ncu_sii_pktq.sv
// Synchronous packet FIFO with occupancy count; head is presented combinationally.
module ncu_sii_pktq #(
  parameter int WIDTH = 129,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             iol2clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             vld,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign do_push = push && (!full || do_pop);

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge iol2clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Storage array, not reset: contents are only visible while vld is high.
  always_ff @(posedge iol2clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign vld  = (count != '0);
  assign head = mem[rd_ptr];

endmodule

// File: rtl/ncu_sii_ingress.sv
// SII -> NCU ingress: grants SII, captures a 4-beat packet with parity check,
// and queues it for the consumer.
module ncu_sii_ingress
  import ncu_sii_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              iol2clk,
  input  logic              rst,
  input  logic              sii_ncu_req,
  input  logic [BEAT_W-1:0] sii_ncu_data,
  input  logic [1:0]        sii_ncu_dparity,
  output logic              ncu_sii_gnt,
  output logic              pkt_vld,
  input  logic              pkt_rdy,
  output logic [PKT_W-1:0]  pkt_data,
  output logic [HDR_W-1:0]  pkt_hdr,
  output logic              pkt_perr,
  output logic [7:0]        perr_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;

  ncu_state_t        state;
  logic [1:0]        beat_cnt;
  logic [BEAT_W-1:0] beat_q [NUM_BEATS-1];
  logic              perr_acc;
  logic              beat_err;
  logic              pkt_err;
  logic              push;
  logic [PKT_W:0]    push_data;
  logic [PKT_W:0]    head;
  logic [CW-1:0]     q_count;

  assign beat_err  = beat_perr(sii_ncu_data, sii_ncu_dparity);
  assign pkt_err   = perr_acc | beat_err;
  // Beat 3 goes straight from the bus into the queue; only beats 0..2 are staged.
  assign push      = (state == CAP) && (beat_cnt == 2'd3);
  assign push_data = {pkt_err, sii_ncu_data, beat_q[2], beat_q[1], beat_q[0]};

  // Control FSM: space check on the registered count, one-cycle grant, beat counting.
  always_ff @(posedge iol2clk) begin
    if (rst) begin
      state       <= IDLE;
      beat_cnt    <= '0;
      ncu_sii_gnt <= 1'b0;
      perr_acc    <= 1'b0;
    end else begin
      ncu_sii_gnt <= 1'b0;
      case (state)
        IDLE: begin
          if (sii_ncu_req && (q_count < CW'(DEPTH))) begin
            state       <= GNT;
            ncu_sii_gnt <= 1'b1;
          end
        end
        GNT: begin
          state    <= CAP;
          beat_cnt <= '0;
          perr_acc <= 1'b0;
        end
        CAP: begin
          beat_cnt <= beat_cnt + 2'd1;
          perr_acc <= pkt_err;
          if (beat_cnt == 2'd3) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage beats 0..2 while capturing.
  always_ff @(posedge iol2clk) begin
    if (state == CAP) begin
      case (beat_cnt)
        2'd0:    beat_q[0] <= sii_ncu_data;
        2'd1:    beat_q[1] <= sii_ncu_data;
        2'd2:    beat_q[2] <= sii_ncu_data;
        default: ;
      endcase
    end
  end

  // Saturating count of errored packets, stepped on push.
  always_ff @(posedge iol2clk) begin
    if (rst) begin
      perr_cnt <= '0;
    end else if (push && pkt_err && (perr_cnt != 8'hFF)) begin
      perr_cnt <= perr_cnt + 8'd1;
    end
  end

  ncu_sii_pktq #(
    .WIDTH (PKT_W + 1),
    .DEPTH (DEPTH)
  ) u_pktq (
    .iol2clk   (iol2clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pkt_rdy),
    .vld       (pkt_vld),
    .head      (head),
    .count     (q_count)
  );

  assign pkt_data = head[PKT_W-1:0];
  assign pkt_hdr  = head[HDR_W-1:0];
  assign pkt_perr = head[PKT_W];

endmodule

// File: tb/tb_ncu_sii_ingress.sv
// Scoreboard bench for ncu_sii_ingress: driver answers grants with packets and
// records expected queue contents; a negedge monitor checks everything the DUT presents.
module tb_ncu_sii_ingress;

  localparam int DEPTH = 4;

  logic         iol2clk = 1'b0;
  logic         rst = 1'b1;
  logic         sii_ncu_req = 1'b0;
  logic [31:0]  sii_ncu_data = '0;
  logic [1:0]   sii_ncu_dparity = '0;
  logic         ncu_sii_gnt;
  logic         pkt_vld;
  logic         pkt_rdy = 1'b0;
  logic [127:0] pkt_data;
  logic [15:0]  pkt_hdr;
  logic         pkt_perr;
  logic [7:0]   perr_cnt;

  always #5 iol2clk = ~iol2clk;

  ncu_sii_ingress #(.DEPTH(DEPTH)) dut (
    .iol2clk         (iol2clk),
    .rst             (rst),
    .sii_ncu_req     (sii_ncu_req),
    .sii_ncu_data    (sii_ncu_data),
    .sii_ncu_dparity (sii_ncu_dparity),
    .ncu_sii_gnt     (ncu_sii_gnt),
    .pkt_vld         (pkt_vld),
    .pkt_rdy         (pkt_rdy),
    .pkt_data        (pkt_data),
    .pkt_hdr         (pkt_hdr),
    .pkt_perr        (pkt_perr),
    .perr_cnt        (perr_cnt)
  );

  typedef struct packed {
    logic [3:0][31:0] beat;
    logic [3:0][1:0]  par;
  } pkt_t;

  typedef struct packed {
    logic         perr;
    logic [127:0] data;
  } exp_t;

  int          vectors = 0;
  int          miscompares = 0;
  exp_t        sb[$];
  pkt_t        force_q[$];
  int          err_mode = 0;   // 0: occasional error, 1: always errored
  int unsigned perr_exp = 0;
  int          pushes = 0;
  int          pops = 0;
  int          cyc = 0;
  int          gnt_total = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name, input int bound);
    vectors++;
    miscompares++;
    $display("FAIL %s: no event within %0d cycles", name, bound);
  endtask

  function automatic pkt_t rand_pkt(input int mode);
    pkt_t p;
    int   b;
    int   i;
    for (int k = 0; k < 4; k++) begin
      p.beat[k] = $urandom;
      p.par[k]  = {^p.beat[k][31:16], ^p.beat[k][15:0]};
    end
    if (mode == 1 || $urandom_range(0, 3) == 0) begin
      b = $urandom_range(0, 3);
      i = $urandom_range(0, 1);
      p.par[b][i] = ~p.par[b][i];
    end
    return p;
  endfunction

  always @(posedge iol2clk) cyc++;

  // Driver: after a grant, drive beats 0..3 on the following four cycles.
  int   slot = -1;
  bit   pending = 1'b0;
  pkt_t cur;
  exp_t drv_e;
  always @(posedge iol2clk) begin
    if (rst) begin
      slot = -1;
      pending = 1'b0;
      sb.delete();
      perr_exp = 0;
    end else if (slot == 3) begin
      drv_e.data = cur.beat;
      drv_e.perr = 1'b0;
      for (int b = 0; b < 4; b++)
        for (int i = 0; i < 2; i++)
          if (cur.par[b][i] != ^cur.beat[b][16*i +: 16]) drv_e.perr = 1'b1;
      sb.push_back(drv_e);
      pushes++;
      if (drv_e.perr && perr_exp < 255) perr_exp++;
      slot = -1;
    end
    #1;
    if (slot >= 0) begin
      slot++;
      sii_ncu_data    = cur.beat[slot];
      sii_ncu_dparity = cur.par[slot];
    end else if (pending) begin
      pending = 1'b0;
      cur = (force_q.size() != 0) ? force_q.pop_front() : rand_pkt(err_mode);
      slot = 0;
      sii_ncu_data    = cur.beat[0];
      sii_ncu_dparity = cur.par[0];
    end else begin
      sii_ncu_data    = $urandom;
      sii_ncu_dparity = 2'($urandom);
    end
    if (ncu_sii_gnt) pending = 1'b1;
  end

  // Monitor: queue state, error counter, grant rules, and popped packets.
  int   last_gnt = -100;
  logic prev_gnt = 1'b0;
  exp_t mon_e;
  always @(negedge iol2clk) begin
    if (rst) begin
      last_gnt = -100;
      prev_gnt = 1'b0;
    end else begin
      check("pkt_vld", pkt_vld, sb.size() != 0);
      check("perr_cnt", perr_cnt, perr_exp);
      if (ncu_sii_gnt) begin
        gnt_total++;
        check("gnt_single_cycle", prev_gnt, 1'b0);
        if (last_gnt >= 0) check("gnt_spacing_ge6", (cyc - last_gnt) >= 6, 1'b1);
        last_gnt = cyc;
      end
      prev_gnt = ncu_sii_gnt;
      if (pkt_vld && pkt_rdy && sb.size() != 0) begin
        mon_e = sb.pop_front();
        pops++;
        check("pkt_data", pkt_data, mon_e.data);
        check("pkt_hdr", pkt_hdr, mon_e.data[15:0]);
        check("pkt_perr", pkt_perr, mon_e.perr);
      end
    end
  end

  task automatic tick();
    @(posedge iol2clk);
    #1;
  endtask

  task automatic wait_gnt(input int bound, output int c);
    c = -1;
    for (int k = 0; k < bound; k++) begin
      tick();
      if (ncu_sii_gnt) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) timeout("wait_gnt", bound);
  endtask

  task automatic wait_vld(input int bound, output int c);
    c = -1;
    for (int k = 0; k < bound; k++) begin
      tick();
      if (pkt_vld) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) timeout("wait_vld", bound);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   t0, g, g2, g3, c, p, r, c0;
    pkt_t fp;

    // Reset values
    rst = 1'b1;
    repeat (3) tick();
    check("rst_gnt", ncu_sii_gnt, 1'b0);
    check("rst_vld", pkt_vld, 1'b0);
    check("rst_perr_cnt", perr_cnt, 8'd0);
    rst = 1'b0;
    repeat (2) tick();

    // Single packet with known content and timing
    fp.beat = {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000A5A};
    fp.par  = '0;
    force_q.push_back(fp);
    sii_ncu_req = 1'b1;
    t0 = cyc;
    wait_gnt(4, g);
    sii_ncu_req = 1'b0;
    check("first_gnt_cycle", g, t0 + 1);
    wait_vld(20, c);
    check("first_vld_cycle", c, t0 + 6);
    check("first_hdr", pkt_hdr, 16'h0A5A);
    check("first_perr", pkt_perr, 1'b0);
    check("first_data", pkt_data, 128'h33333333_22222222_11111111_00000A5A);
    pkt_rdy = 1'b1;
    tick();
    pkt_rdy = 1'b0;
    tick();

    // Parity error on beat 2
    fp.par[2] = 2'b01;
    force_q.push_back(fp);
    sii_ncu_req = 1'b1;
    wait_gnt(4, g);
    sii_ncu_req = 1'b0;
    wait_vld(20, c);
    check("perr_flag", pkt_perr, 1'b1);
    check("perr_cnt_one", perr_cnt, 8'd1);
    pkt_rdy = 1'b1;
    tick();

    // 300 errored packets saturate the counter
    err_mode = 1;
    sii_ncu_req = 1'b1;
    for (int k = 0; k < 300; k++) wait_gnt(10, g);
    sii_ncu_req = 1'b0;
    repeat (10) tick();
    check("perr_cnt_sat", perr_cnt, 8'd255);
    err_mode = 0;

    // Backpressure: exactly DEPTH grants, next grant only after a pop
    pkt_rdy = 1'b0;
    sii_ncu_req = 1'b1;
    c0 = gnt_total;
    repeat (60) tick();
    check("bp_grants", gnt_total - c0, DEPTH);
    check("bp_vld", pkt_vld, 1'b1);
    pkt_rdy = 1'b1;
    p = cyc;
    tick();
    pkt_rdy = 1'b0;
    wait_gnt(20, g);
    check("gnt_after_pop_ge2", (g - p) >= 2, 1'b1);
    sii_ncu_req = 1'b0;
    pkt_rdy = 1'b1;
    repeat (15) tick();
    check("bp_drained", pkt_vld, 1'b0);

    // Streaming: grants every 6 cycles, nothing lost
    sii_ncu_req = 1'b1;
    wait_gnt(10, g);
    for (int k = 0; k < 10; k++) begin
      wait_gnt(10, g2);
      check("stream_spacing", g2 - g, 6);
      g = g2;
    end
    sii_ncu_req = 1'b0;
    repeat (12) tick();
    check("stream_no_loss", pops, pushes);

    // Random request/consumer traffic
    for (int k = 0; k < 400; k++) begin
      sii_ncu_req = 1'($urandom_range(0, 1));
      pkt_rdy = ($urandom_range(0, 3) != 0);
      tick();
    end
    sii_ncu_req = 1'b0;
    pkt_rdy = 1'b1;
    repeat (30) tick();
    check("random_no_loss", pops, pushes);

    // Reset during beat 1 discards the packet
    sii_ncu_req = 1'b1;
    wait_gnt(10, g);
    sii_ncu_req = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("midrst_gnt", ncu_sii_gnt, 1'b0);
    check("midrst_vld", pkt_vld, 1'b0);
    check("midrst_perr_cnt", perr_cnt, 8'd0);
    rst = 1'b0;
    sii_ncu_req = 1'b1;
    r = cyc;
    wait_gnt(5, g2);
    sii_ncu_req = 1'b0;
    check("post_rst_gnt_cycle", g2, r + 1);
    repeat (12) tick();

    // Simultaneous push and pop with two packets queued
    pkt_rdy = 1'b0;
    sii_ncu_req = 1'b1;
    wait_gnt(10, g);
    wait_gnt(10, g2);
    wait_gnt(10, g3);
    sii_ncu_req = 1'b0;
    repeat (4) tick();
    check("simul_count_before", dut.u_pktq.count, 2);
    pkt_rdy = 1'b1;
    tick();
    pkt_rdy = 1'b0;
    check("simul_count_after", dut.u_pktq.count, 2);
    if (sb.size() != 0) check("simul_head", pkt_data, sb[0].data);
    else timeout("simul_head_model", 0);
    pkt_rdy = 1'b1;
    repeat (6) tick();
    check("simul_drained", pkt_vld, 1'b0);
    check("final_no_loss", pops, pushes);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ncu_sii_ingress.md
NCU_SII_INGRESS -- requirements
Module: ncu_sii_ingress

Interface
REQ-001 SHALL have parameter DEPTH, default 4, setting the packet queue depth; legal values are powers of 2 and at least 2.
REQ-002 SHALL have port iol2clk, input, 1 bit: the only clock, rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port sii_ncu_req, input, 1 bit: level request from SII that a packet is pending.
REQ-005 SHALL have port sii_ncu_data, input, 32 bits: payload beat.
REQ-006 SHALL have port sii_ncu_dparity, input, 2 bits: bit i is even parity over sii_ncu_data[16i+15:16i].
REQ-007 SHALL have port ncu_sii_gnt, output, 1 bit: one-cycle grant to SII.
REQ-008 SHALL have port pkt_vld, output, 1 bit: queue head valid.
REQ-009 SHALL have port pkt_rdy, input, 1 bit: consumer pop; the pop occurs when pkt_vld and pkt_rdy are both 1.
REQ-010 SHALL have port pkt_data, output, 128 bits: {beat3,beat2,beat1,beat0}.
REQ-011 SHALL have port pkt_hdr, output, 16 bits: beat0[15:0] of the head packet.
REQ-012 SHALL have port pkt_perr, output, 1 bit: head packet had a parity error.
REQ-013 SHALL have port perr_cnt, output, 8 bits: saturating count of errored packets.

Function
REQ-014 SHALL implement FSM states IDLE, GNT, CAP.
- IDLE -> GNT when sii_ncu_req=1 and registered queue count < DEPTH.
- GNT -> CAP unconditionally.
- CAP -> IDLE after beat 3 is captured.
REQ-015 SHALL drive ncu_sii_gnt from a flop, equal to 1 exactly during the GNT state.
REQ-016 SHALL capture beats 0..3 in the four consecutive cycles following the GNT cycle, using a 2-bit beat counter that wraps 3->0.
REQ-017 SHALL sample sii_ncu_req only in IDLE; req held high while the FSM is in GNT or CAP SHALL NOT produce an extra grant.
REQ-018 SHALL give a back-to-back minimum grant spacing of 6 cycles (grant at T, beats at T+1..T+4, IDLE at T+5, next grant at T+6).
REQ-019 SHALL check parity on every beat; pkt_perr for a packet is the OR of all 8 half-word mismatches.
REQ-020 SHALL push the packet into the queue in the cycle beat 3 is captured, so it appears at pkt_vld on the next cycle if the queue was empty.
REQ-021 SHALL, on simultaneous push and pop, leave the count unchanged and keep data ordering FIFO.
REQ-022 SHALL compute the space check from the count at the start of the cycle; a same-cycle pop SHALL NOT enable a grant.
REQ-023 SHALL never overflow: a grant is only issued with a free slot, and a slot is reserved until the push.
REQ-024 SHALL, when the queue is empty, drive pkt_vld=0; pkt_data, pkt_hdr and pkt_perr are don't-care; a pop with pkt_vld=0 SHALL be ignored.
REQ-025 SHALL increment perr_cnt by 1 on the push of each errored packet, saturating at 255.

Reset
REQ-026 SHALL, with rst=1 at a clock edge, set FSM=IDLE, beat counter=0, ncu_sii_gnt=0, queue empty (pkt_vld=0) and perr_cnt=0.
REQ-027 SHALL, on reset during GNT or CAP, discard the partial packet without pushing it; the next grant requires a fresh req in IDLE.

Structure
REQ-028 SHALL place the state enum, NUM_BEATS=4, BEAT_W=32, PKT_W=128 and HDR_W=16 in shared package ncu_sii_pkg.
REQ-029 SHALL implement the queue as sub-module ncu_sii_pktq, a synchronous FIFO of width PKT_W+1 (the extra bit is perr) and depth DEPTH, exposing a count output.

Verification
REQ-030 SHALL cover single packet: req=1 at T0 with beats 0x00000A5A, 0x11111111, 0x22222222, 0x33333333 and correct parity -> gnt at T1, pkt_vld at T6, pkt_hdr=0x0A5A, pkt_perr=0, pkt_data=0x33333333_22222222_11111111_00000A5A.
REQ-031 SHALL cover a parity error: beat2 parity flipped to 2'b01 -> pkt_perr=1 and perr_cnt 0->1; 300 errored packets -> perr_cnt=255.
REQ-032 SHALL cover backpressure: pkt_rdy=0 with req held, DEPTH=4 -> exactly 4 grants, no 5th; one pop -> next grant no earlier than 2 cycles after the pop.
REQ-033 SHALL cover streaming: req held, pkt_rdy=1 -> grants every 6 cycles, packets output in order with no loss.
REQ-034 SHALL cover reset mid-capture: rst=1 during beat 1 -> no push, pkt_vld=0, gnt=0; after release with req=1 -> grant on the second cycle.
REQ-035 SHALL cover simultaneous push/pop with count=2 -> count stays 2 and the head advances correctly.
